data_axi_bridge: RTL and testbench
==================================

# data_axi_bridge

Single-outstanding bridge between the CPU core's data-side request/handshake port and an AXI3/AXI4 master port. Sits directly downstream of the core's execute/writeback memory interface: it accepts one load or store per transaction on `data_req`/`data_addr_ok`, issues a single-beat AXI transfer, and returns completion on `data_data_ok` with read data on `data_rdata`. Error responses are reported on a sticky-free pulse output for CP0/debug use.

## Interface
- `AXI_ID`, default 4'd1: constant ID driven on `arid`/`awid`.
- `clk`  in  1  system clock, all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `data_req`  in  1  core request valid.
- `data_wr`  in  1  1 = store, 0 = load.
- `data_cache`  in  1  1 = cacheable attribute.
- `data_size`  in  3  log2 bytes (0/1/2), passed to `arsize`/`awsize`.
- `data_addr`  in  32  physical byte address.
- `data_wstrb`  in  4  store byte enables.
- `data_wdata`  in  32  store data.
- `data_addr_ok`  out  1  request accepted this cycle.
- `data_data_ok`  out  1  transaction complete this cycle.
- `data_rdata`  out  32  load data, valid with `data_data_ok` on loads.
- `arid/araddr/arlen/arsize/arburst/arcache/arvalid`  out  4/32/8/3/2/4/1; `arready` in 1.
- `rid/rdata/rresp/rlast/rvalid`  in  4/32/2/1/1; `rready` out 1.
- `awid/awaddr/awlen/awsize/awburst/awcache/awvalid`  out  4/32/8/3/2/4/1; `awready` in 1.
- `wdata/wstrb/wlast/wvalid`  out  32/4/1/1; `wready` in 1.
- `bid/bresp/bvalid`  in  4/2/1; `bready` out 1.
- `bus_err`  out  1  one-cycle pulse when `rresp` or `bresp` != OKAY at completion.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: `data_addr_ok = data_req`. On accept latch wr, size, addr, wstrb, wdata, cache; go RD_ADDR (load) or WR_REQ (store).
- RD_ADDR: `arvalid=1` with latched fields; on `arready` -> RD_DATA.
- RD_DATA: `rready=1`; on `rvalid` -> `data_data_ok=1`, `data_rdata=rdata` (combinational pass-through), `bus_err=(rresp!=0)`, -> IDLE.
- WR_REQ: `awvalid` and `wvalid` raised together; flags `aw_done`, `w_done` set on respective handshakes and drop the matching valid. Leave when both done (including both in the same cycle, or one done via flag plus other this cycle) -> WR_RESP, flags cleared.
- WR_RESP: `bready=1`; on `bvalid` -> `data_data_ok=1`, `bus_err=(bresp!=0)`, -> IDLE.
- Constants: `arlen=awlen=0`, `arburst=awburst=2'b01`, `wlast=1`, `arcache/awcache = cache ? 4'b1111 : 4'b0000`, `rid`/`bid` ignored.
- Only one transaction outstanding; `data_addr_ok` is 0 in every non-IDLE state, including the completion cycle.
- `data_rdata` outside RD_DATA completion is don't-care; drive `rdata`.

## Timing
- Reset (async assert): state IDLE, all latched fields 0, flags 0; all `*valid`, `*ready`, `data_addr_ok`, `data_data_ok`, `bus_err` = 0. Outputs reach these values without a clock edge.
- Reset mid-transaction abandons AXI handshake; interconnect is reset with the same `resetn`.
- Load latency with zero-wait slave: accept cycle T, `arvalid` T+1, `rvalid` earliest T+2, `data_data_ok` T+2. Store: `awvalid/wvalid` T+1, `bvalid` earliest T+2, `data_data_ok` T+2.
- Back-to-back: next `data_addr_ok` earliest one cycle after `data_data_ok`.
- Valids held stable until handshake; latched payload never changes while a valid is high.

## Structure
- Shared package/header (`common.vh`): state encodings, `AXI_BURST_INCR`, `AXI_RESP_OKAY`, cache attribute constants.
- Single module; no sub-module needed. Write-channel join (aw/w flags) kept inline.

## Test plan
- Load, zero-wait slave, addr 0x1FC0_0000, `rdata=0xDEADBEEF` -> `arvalid` T+1, `data_data_ok` T+2, `data_rdata=0xDEADBEEF`, `bus_err=0`.
- Store addr 0x8000_0010, wstrb 4'b0011, size 1; `wready` 3 cycles before `awready` -> `awvalid` drops after its handshake, `bready` only after both done, one `data_data_ok`.
- Store with `awready` and `wready` same cycle T+1, `bvalid` T+3 -> WR_RESP at T+2, `data_data_ok` T+3.
- `data_req` held high continuously through a load -> `data_addr_ok` only in IDLE; second request accepted cycle after first `data_data_ok`.
- Load with `rresp=2'b10` -> `data_data_ok` and `bus_err` both pulse one cycle.
- Assert `resetn=0` mid-cycle while `arvalid=1` -> `arvalid`, `rready`, `data_addr_ok` low immediately; first request after release accepted normally.

Source files
------------

// File: rtl/data_axi_bridge_pkg.sv
// Shared encodings for the core-data to AXI bridge.
package data_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_ON   = 4'b1111;
  localparam logic [3:0] AXI_CACHE_OFF  = 4'b0000;

  // Request fields captured at acceptance and held for the whole transaction.
  typedef struct packed {
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        cache;
  } req_t;

  function automatic logic [3:0] cache_attr(input logic c);
    return c ? AXI_CACHE_ON : AXI_CACHE_OFF;
  endfunction

endpackage

// File: rtl/data_axi_bridge_if.sv
// Core data port plus AXI master channels. 'master' is the bridge side.
interface data_axi_bridge_if;
  // core side
  logic        data_req, data_wr, data_cache;
  logic [2:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  // AXI read
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  // AXI write
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  // status
  logic        bus_err;

  modport master (
    input  data_req, data_wr, data_cache, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output bus_err
  );

  modport slave (
    output data_req, data_wr, data_cache, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  bus_err
  );
endinterface

// File: rtl/data_axi_bridge.sv
// Single-outstanding bridge: one core load/store -> one single-beat AXI transfer.
module data_axi_bridge
  import data_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic              clk,
  input  logic              resetn,
  data_axi_bridge_if.master bus
);

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic   aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic   addr_ok_c, aw_fin, w_fin;

  // State, latched request and write-join flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next state and all handshake outputs; everything is zero outside its state.
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    aw_done_d        = aw_done_q;
    w_done_d         = w_done_q;
    addr_ok_c        = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.bus_err      = 1'b0;
    bus.arvalid      = 1'b0;
    bus.rready       = 1'b0;
    bus.awvalid      = 1'b0;
    bus.wvalid       = 1'b0;
    bus.bready       = 1'b0;
    // a channel counts as done if flagged earlier or handshaking now
    aw_fin           = aw_done_q | bus.awready;
    w_fin            = w_done_q  | bus.wready;
    case (state_q)
      ST_IDLE: begin
        addr_ok_c = bus.data_req;
        if (bus.data_req) begin
          req_d   = '{wr: bus.data_wr, size: bus.data_size, addr: bus.data_addr,
                      wstrb: bus.data_wstrb, wdata: bus.data_wdata, cache: bus.data_cache};
          state_d = bus.data_wr ? ST_WR_REQ : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        bus.rready = 1'b1;
        if (bus.rvalid) begin
          bus.data_data_ok = 1'b1;
          bus.bus_err      = (bus.rresp != AXI_RESP_OKAY);
          state_d          = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        bus.awvalid = !aw_done_q;
        bus.wvalid  = !w_done_q;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WR_RESP;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end
      ST_WR_RESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) begin
          bus.data_data_ok = 1'b1;
          bus.bus_err      = (bus.bresp != AXI_RESP_OKAY);
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // addr_ok follows data_req in IDLE, so it must be forced low while reset is held.
  assign bus.data_addr_ok = resetn & addr_ok_c;
  assign bus.data_rdata   = bus.rdata;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = req_q.addr;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = req_q.size;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arcache = cache_attr(req_q.cache);

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = req_q.addr;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = req_q.size;
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awcache = cache_attr(req_q.cache);

  assign bus.wdata = req_q.wdata;
  assign bus.wstrb = req_q.wstrb;
  assign bus.wlast = 1'b1;

  // IDs and rlast carry no information for single-beat, single-ID traffic.
  logic unused_ok;
  assign unused_ok = ^{bus.rid, bus.rlast, bus.bid};

endmodule

// File: tb/tb_data_axi_bridge.sv
// Directed bench for data_axi_bridge: zero-wait and stalled AXI slave behaviour.
module tb_data_axi_bridge;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  data_axi_bridge_if bus ();

  data_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; inputs are driven there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.data_req = 0; bus.data_wr = 0; bus.data_cache = 0; bus.data_size = 0;
    bus.data_addr = 0; bus.data_wstrb = 0; bus.data_wdata = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 1; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;

    // ---- reset state, with a pending request held ----
    bus.data_req = 1;
    #3;
    chk("rst_addr_ok", bus.data_addr_ok, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid",  bus.wvalid, 0);
    chk("rst_rready",  bus.rready, 0);
    chk("rst_bready",  bus.bready, 0);
    chk("rst_data_ok", bus.data_data_ok, 0);
    chk("rst_bus_err", bus.bus_err, 0);
    chk("rst_araddr",  bus.araddr, 0);
    bus.data_req = 0;
    #9 resetn = 1;

    // ---- load, zero-wait slave ----
    step();
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h1FC0_0000;
    bus.data_size = 3'd2; bus.data_cache = 1;
    #1 chk("ld_addr_ok_T", bus.data_addr_ok, 1);
    step();  // T+1
    bus.data_req = 0; bus.arready = 1;
    #1;
    chk("ld_arvalid_T1", bus.arvalid, 1);
    chk("ld_araddr",     bus.araddr, 32'h1FC0_0000);
    chk("ld_arsize",     bus.arsize, 2);
    chk("ld_arlen",      bus.arlen, 0);
    chk("ld_arburst",    bus.arburst, 1);
    chk("ld_arcache",    bus.arcache, 4'hF);
    chk("ld_arid",       bus.arid, 1);
    chk("ld_no_ok_T1",   bus.data_data_ok, 0);
    step();  // T+2
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 0;
    #1;
    chk("ld_rready_T2",  bus.rready, 1);
    chk("ld_arvalid_lo", bus.arvalid, 0);
    chk("ld_data_ok_T2", bus.data_data_ok, 1);
    chk("ld_rdata",      bus.data_rdata, 32'hDEAD_BEEF);
    chk("ld_bus_err",    bus.bus_err, 0);
    step();
    bus.rvalid = 0;
    #1 chk("ld_ok_pulse", bus.data_data_ok, 0);

    // ---- store, W handshakes 3 cycles before AW ----
    bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h8000_0010;
    bus.data_wstrb = 4'b0011; bus.data_size = 3'd1; bus.data_wdata = 32'h1234_5678;
    bus.data_cache = 0;
    #1 chk("st_addr_ok", bus.data_addr_ok, 1);
    step();  // T+1
    bus.data_req = 0; bus.wready = 1;
    #1;
    chk("st_awvalid_T1", bus.awvalid, 1);
    chk("st_wvalid_T1",  bus.wvalid, 1);
    chk("st_wstrb",      bus.wstrb, 4'b0011);
    chk("st_wdata",      bus.wdata, 32'h1234_5678);
    chk("st_wlast",      bus.wlast, 1);
    chk("st_awcache",    bus.awcache, 0);
    step();  // T+2
    bus.wready = 0;
    #1;
    chk("st_wvalid_drop", bus.wvalid, 0);
    chk("st_awvalid_T2",  bus.awvalid, 1);
    chk("st_bready_T2",   bus.bready, 0);
    step();  // T+3
    #1;
    chk("st_awvalid_T3", bus.awvalid, 1);
    chk("st_bready_T3",  bus.bready, 0);
    step();  // T+4
    bus.awready = 1;
    #1;
    chk("st_awvalid_T4", bus.awvalid, 1);
    chk("st_awaddr",     bus.awaddr, 32'h8000_0010);
    chk("st_awsize",     bus.awsize, 1);
    chk("st_wvalid_T4",  bus.wvalid, 0);
    chk("st_no_ok_T4",   bus.data_data_ok, 0);
    step();  // T+5
    bus.awready = 0; bus.bvalid = 1; bus.bresp = 0;
    #1;
    chk("st_awvalid_drop", bus.awvalid, 0);
    chk("st_bready",       bus.bready, 1);
    chk("st_data_ok",      bus.data_data_ok, 1);
    chk("st_bus_err",      bus.bus_err, 0);
    step();
    bus.bvalid = 0;
    #1 chk("st_ok_pulse", bus.data_data_ok, 0);

    // ---- store, AW and W together, delayed B ----
    bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h0000_0100;
    bus.data_wstrb = 4'hF; bus.data_size = 3'd2; bus.data_wdata = 32'hA5A5_0001;
    step();  // T+1
    bus.data_req = 0; bus.awready = 1; bus.wready = 1;
    #1;
    chk("st2_awvalid", bus.awvalid, 1);
    chk("st2_wvalid",  bus.wvalid, 1);
    step();  // T+2
    bus.awready = 0; bus.wready = 0;
    #1;
    chk("st2_bready_T2", bus.bready, 1);
    chk("st2_aw_lo_T2",  bus.awvalid, 0);
    chk("st2_w_lo_T2",   bus.wvalid, 0);
    chk("st2_no_ok_T2",  bus.data_data_ok, 0);
    step();  // T+3
    bus.bvalid = 1;
    #1 chk("st2_ok_T3", bus.data_data_ok, 1);
    step();
    bus.bvalid = 0;

    // ---- data_req held high, first load returns SLVERR ----
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h0000_0040; bus.data_cache = 0;
    #1 chk("hold_addr_ok_T", bus.data_addr_ok, 1);
    step();  // T+1
    bus.arready = 1;
    #1 chk("hold_addr_ok_T1", bus.data_addr_ok, 0);
    step();  // T+2
    bus.arready = 0; bus.rvalid = 1; bus.rresp = 2'b10; bus.rdata = 32'h0000_CAFE;
    #1;
    chk("err_data_ok",      bus.data_data_ok, 1);
    chk("err_bus_err",      bus.bus_err, 1);
    chk("hold_addr_ok_T2",  bus.data_addr_ok, 0);
    step();  // T+3: second request accepted
    bus.rvalid = 0; bus.rresp = 0;
    #1;
    chk("hold_addr_ok_T3", bus.data_addr_ok, 1);
    chk("err_pulse",       bus.bus_err, 0);
    chk("err_ok_pulse",    bus.data_data_ok, 0);
    step();
    bus.data_req = 0; bus.arready = 1;
    #1;
    chk("hold2_arvalid", bus.arvalid, 1);
    chk("hold2_araddr",  bus.araddr, 32'h0000_0040);
    chk("hold2_arcache", bus.arcache, 0);
    step();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h0000_0001;
    #1;
    chk("hold2_data_ok", bus.data_data_ok, 1);
    chk("hold2_bus_err", bus.bus_err, 0);
    step();
    bus.rvalid = 0;

    // ---- async reset while arvalid is high ----
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h0000_2000;
    step();
    #1 chk("mr_arvalid_pre", bus.arvalid, 1);
    #1 resetn = 0;
    #1;
    chk("mr_arvalid", bus.arvalid, 0);
    chk("mr_rready",  bus.rready, 0);
    chk("mr_addr_ok", bus.data_addr_ok, 0);
    chk("mr_araddr",  bus.araddr, 0);
    step();
    resetn = 1;
    #1 chk("mr_accept", bus.data_addr_ok, 1);
    step();
    bus.data_req = 0; bus.arready = 1;
    #1;
    chk("mr_arvalid_post", bus.arvalid, 1);
    chk("mr_araddr_post",  bus.araddr, 32'h0000_2000);
    step();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h0000_0055;
    #1;
    chk("mr_data_ok", bus.data_data_ok, 1);
    chk("mr_rdata",   bus.data_rdata, 32'h0000_0055);
    step();
    bus.rvalid = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
